// File: rtl/serial_parallel_if.sv
// serial_parallel_if
//   Groups the host word stream and the Keccak block handshake of serial_parallel.
//   Word stream : in_data[63:0] (stream byte 0 in [63:56]), in_valid, in_last,
//                 in_bytes[3:0] (valid bytes in the final word), in_ready.
//   Block side  : blk_data[1599:0], blk_valid, blk_first, blk_last, blk_ack.
//   Modports    : slave  - the serial_parallel block itself.
//                 master - the host / permutation core environment around it.
interface serial_parallel_if;
   logic [63:0]   in_data;
   logic          in_valid;
   logic          in_last;
   logic [3:0]    in_bytes;
   logic          in_ready;
   logic [1599:0] blk_data;
   logic          blk_valid;
   logic          blk_first;
   logic          blk_last;
   logic          blk_ack;

   modport slave (
      input  in_data, in_valid, in_last, in_bytes, blk_ack,
      output in_ready, blk_data, blk_valid, blk_first, blk_last
   );

   modport master (
      output in_data, in_valid, in_last, in_bytes, blk_ack,
      input  in_ready, blk_data, blk_valid, blk_first, blk_last
   );
endinterface

// File: rtl/serial_parallel.sv
// serial_parallel
//   Packs a stream of 64-bit message words into rate-sized Keccak absorb blocks.
//   Each word is byte-reversed into a lane (word byte k -> lane bits [8k+7:8k]),
//   lane j of the block appears at blk_data[64j+63:64j]; lanes >= RATE_LANES are 0.
//   Optional feature macro SHA3_PAD_EN: when defined, the final word is trimmed to
//   in_bytes bytes and SHA3 padding (0x06 ... 0x80) is applied on chip, adding a
//   pad-only block when the message exactly fills the last block. When undefined,
//   words are stored whole and the host supplies a pre-padded message.
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : serial_parallel_if.slave (word stream in, block handshake out)
// Parameter
//   RATE_LANES : lanes per block, 2..24 (17 = SHA3-256)
module serial_parallel #(
   parameter int RATE_LANES = 17
) (
   input logic             clk,
   input logic             reset,
   serial_parallel_if.slave bus
);
   localparam int CW = $clog2(RATE_LANES);
   localparam logic [CW-1:0] LAST_LANE = CW'(RATE_LANES - 1);

   typedef enum logic {S_FILL, S_SEND} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [63:0]   r_lanes      [RATE_LANES];
   logic [63:0]   w_fill_lanes [RATE_LANES];
   logic [CW-1:0] r_lane_cnt;
   logic          r_first_flag;
   logic          r_extra_pend;
   logic          r_blk_last;
   logic          w_accept;
   logic          w_lane_full;
   logic          w_pad_extra;
   logic          w_in_ready;
   logic          w_blk_valid;
   logic [3:0]    w_nbytes;
   logic [63:0]   w_word_lane;
   logic [1599:0] w_blk_data;

   assign w_lane_full = (r_lane_cnt == LAST_LANE);

`ifdef SHA3_PAD_EN
   logic [63:0] w_pad06;
   // Only the final word is trimmed; byte counts above 8 mean a full word.
   assign w_nbytes    = !bus.in_last ? 4'd8 : ((bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes);
   assign w_pad06     = 64'h06 << {w_nbytes[2:0], 3'b000};
   // A full final word in the last lane leaves no room for padding.
   assign w_pad_extra = bus.in_last && (w_nbytes == 4'd8) && w_lane_full;
`else
   assign w_nbytes    = 4'd8;
   assign w_pad_extra = 1'b0;
`endif

   // Byte reversal into lane order, dropping bytes past the valid count.
   always_comb begin
      w_word_lane = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(w_nbytes)) w_word_lane[8*k +: 8] = bus.in_data[56-8*k +: 8];
      end
   end

   // Lane buffer contents after accepting the current word.
   always_comb begin
      for (int j = 0; j < RATE_LANES; j++) begin
         w_fill_lanes[j] = r_lanes[j];
         if (int'(r_lane_cnt) == j) w_fill_lanes[j] = w_word_lane;
`ifdef SHA3_PAD_EN
         if (bus.in_last && !w_pad_extra) begin
            if ((int'(r_lane_cnt) == j) && (w_nbytes < 4'd8))
               w_fill_lanes[j] = w_fill_lanes[j] | w_pad06;
            if ((int'(r_lane_cnt) + 1 == j) && (w_nbytes == 4'd8))
               w_fill_lanes[j] = w_fill_lanes[j] | 64'h06;
            if (j == RATE_LANES - 1)
               w_fill_lanes[j] = w_fill_lanes[j] | 64'h8000_0000_0000_0000;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FILL;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_blk_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_FILL: begin
            w_in_ready = 1'b1;
            w_accept   = bus.in_valid;
            if (w_accept && (bus.in_last || w_lane_full)) w_state_nxt = S_SEND;
         end
         S_SEND: begin
            w_blk_valid = 1'b1;
            // A pending pad-only block keeps us in SEND for one more handshake.
            if (bus.blk_ack && !r_extra_pend) w_state_nxt = S_FILL;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < RATE_LANES; j++) r_lanes[j] <= '0;
         r_lane_cnt   <= '0;
         r_first_flag <= 1'b1;
         r_extra_pend <= 1'b0;
         r_blk_last   <= 1'b0;
      end else if (w_accept) begin
         r_lanes <= w_fill_lanes;
         if (bus.in_last) begin
            r_blk_last   <= !w_pad_extra;
            r_extra_pend <= w_pad_extra;
         end else if (!w_lane_full) begin
            r_lane_cnt <= r_lane_cnt + CW'(1);
         end
      end else if (w_blk_valid && bus.blk_ack) begin
         r_lane_cnt   <= '0;
         r_first_flag <= 1'b0;
         if (r_extra_pend) begin
            for (int j = 0; j < RATE_LANES; j++)
               r_lanes[j] <= ((j == 0) ? 64'h06 : 64'h0) |
                             ((j == RATE_LANES - 1) ? 64'h8000_0000_0000_0000 : 64'h0);
            r_blk_last   <= 1'b1;
            r_extra_pend <= 1'b0;
         end else begin
            for (int j = 0; j < RATE_LANES; j++) r_lanes[j] <= '0;
            r_blk_last <= 1'b0;
            // The block just absorbed ended a message, so the next one starts fresh.
            if (r_blk_last) r_first_flag <= 1'b1;
         end
      end
   end

   always_comb begin
      w_blk_data = '0;
      for (int j = 0; j < RATE_LANES; j++) w_blk_data[64*j +: 64] = r_lanes[j];
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.blk_valid = w_blk_valid;
   assign bus.blk_data  = w_blk_data;
   assign bus.blk_first = r_first_flag;
   assign bus.blk_last  = r_blk_last;
endmodule

// File: tb/tb_serial_parallel.sv
module tb_serial_parallel;
   localparam int RL = 17;
`ifdef SHA3_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam logic [63:0] HI80 = PAD ? 64'h8000_0000_0000_0000 : 64'h0;
   localparam logic [63:0] P06  = PAD ? 64'h06 : 64'h0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_parallel_if bus ();
   serial_parallel #(.RATE_LANES(RL)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [1599:0] d;
      logic          f;
      logic          l;
   } blk_t;

   blk_t sb[$];
   blk_t e;
   int   total = 0;
   int   bad = 0;
   int   hold_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic chk_blk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
      int lane;
      total++;
      if (act !== exp) begin
         bad++;
         lane = 0;
         for (int j = 24; j >= 0; j--) if (act[64*j +: 64] !== exp[64*j +: 64]) lane = j;
         $display("FAIL %s lane%0d act=%h exp=%h", name, lane, act[64*lane +: 64], exp[64*lane +: 64]);
      end
   endtask

   task automatic e_new(input logic f, input logic l);
      e.d = '0; e.f = f; e.l = l;
   endtask

   task automatic e_lane(input int j, input logic [63:0] v);
      e.d[64*j +: 64] = v;
   endtask

   function automatic logic [63:0] seq_word(input int i);
      return 64'h0001020304050607 + 64'(i) * 64'h0808080808080808;
   endfunction

   function automatic logic [63:0] seq_lane(input int i);
      return 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
   endfunction

   // Entered and left on a falling edge.
   task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
      int cnt;
      bus.in_data = d; bus.in_last = last; bus.in_bytes = nb; bus.in_valid = 1'b1;
      cnt = 0;
      while (bus.in_ready !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 200) begin
         total++; bad++;
         $display("FAIL in_ready_timeout act=0 exp=1");
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   // Monitor / core model: compares each presented block and acknowledges it.
   initial begin
      logic seen;
      logic acked;
      int   held;
      blk_t exp_b;
      seen = 1'b0; acked = 1'b0; held = 0;
      exp_b.d = '0; exp_b.f = 1'b0; exp_b.l = 1'b0;
      bus.blk_ack = 1'b0;
      forever begin
         @(negedge clk);
         bus.blk_ack = 1'b0;
         if (acked && bus.blk_valid !== 1'b1) chk("in_ready_after_ack", 64'(bus.in_ready), 64'd1);
         acked = 1'b0;
         if (reset === 1'b1) begin
            seen = 1'b0;
         end else if (bus.blk_valid === 1'b1) begin
            if (!seen) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_block act=1 exp=0");
               end else begin
                  exp_b = sb.pop_front();
                  chk_blk("blk_data", bus.blk_data, exp_b.d);
                  chk("blk_first", 64'(bus.blk_first), 64'(exp_b.f));
                  chk("blk_last", 64'(bus.blk_last), 64'(exp_b.l));
               end
               seen = 1'b1;
               held = 0;
            end else begin
               chk_blk("blk_data_held", bus.blk_data, exp_b.d);
               chk("in_ready_in_send", 64'(bus.in_ready), 64'd0);
            end
            if (held >= hold_cycles) begin
               bus.blk_ack = 1'b1;
               seen = 1'b0;
               acked = 1'b1;
            end else begin
               held++;
            end
         end
      end
   end

   initial begin
      int cnt;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_bytes = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_blk_first", 64'(bus.blk_first), 64'd1);
      chk("rst_blk_last", 64'(bus.blk_last), 64'd0);
      chk_blk("rst_blk_data", bus.blk_data, '0);

      // Empty message
      e_new(1'b1, 1'b1); e_lane(0, P06); e_lane(16, HI80); sb.push_back(e);
      send_word(64'h0, 1'b1, 4'd0);

      // "abc"
      e_new(1'b1, 1'b1);
      e_lane(0, PAD ? 64'h0000000006636261 : 64'h0000000000636261);
      e_lane(16, HI80); sb.push_back(e);
      send_word(64'h6162630000000000, 1'b1, 4'd3);

      // 136 bytes: exactly one full block, pad goes to an extra block
      e_new(1'b1, !PAD);
      for (int i = 0; i < 17; i++) e_lane(i, seq_lane(i));
      sb.push_back(e);
      if (PAD) begin
         e_new(1'b0, 1'b1); e_lane(0, 64'h06); e_lane(16, 64'h8000000000000000); sb.push_back(e);
      end
      for (int i = 0; i < 17; i++) send_word(seq_word(i), i == 16, 4'd8);

      // 135 bytes: 0x06 and 0x80 coincide in byte 7 of lane 16
      e_new(1'b1, 1'b1);
      for (int i = 0; i < 16; i++) e_lane(i, seq_lane(i));
      e_lane(16, PAD ? 64'h8686858483828180 : 64'h8786858483828180);
      sb.push_back(e);
      for (int i = 0; i < 16; i++) send_word(seq_word(i), 1'b0, 4'd8);
      send_word(64'h8081828384858687, 1'b1, 4'd7);

      // 128 bytes: 0x06 spills into byte 0 of the last lane
      e_new(1'b1, 1'b1);
      for (int i = 0; i < 16; i++) e_lane(i, seq_lane(i));
      e_lane(16, PAD ? 64'h8000000000000006 : 64'h0);
      sb.push_back(e);
      for (int i = 0; i < 16; i++) send_word(seq_word(i), i == 15, 4'd8);

      // Two words, final word carries no bytes
      e_new(1'b1, 1'b1);
      e_lane(0, 64'hEFCDAB8967452301);
      e_lane(1, PAD ? 64'h06 : 64'h00000000EFBEADDE);
      e_lane(16, HI80); sb.push_back(e);
      send_word(64'h0123456789ABCDEF, 1'b0, 4'd8);
      send_word(64'hDEADBEEF00000000, 1'b1, 4'd0);

      // Held acknowledge while the host keeps offering the next message
      hold_cycles = 10;
      e_new(1'b1, 1'b1);
      e_lane(0, 64'h8877665544332211); e_lane(1, P06); e_lane(16, HI80); sb.push_back(e);
      send_word(64'h1122334455667788, 1'b1, 4'd8);
      // in_bytes above 8 behaves as 8
      e_new(1'b1, 1'b1);
      e_lane(0, 64'hA8A7A6A5A4A3A2A1); e_lane(1, P06); e_lane(16, HI80); sb.push_back(e);
      send_word(64'hA1A2A3A4A5A6A7A8, 1'b1, 4'd12);
      hold_cycles = 0;

      // Reset after five words discards the partial block
      for (int i = 0; i < 5; i++) send_word(seq_word(i), 1'b0, 4'd8);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_blk_valid", 64'(bus.blk_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk_blk("mid_rst_blk_data", bus.blk_data, '0);
      e_new(1'b1, 1'b1);
      e_lane(0, PAD ? 64'h0000000006636261 : 64'h0000000000636261);
      e_lane(16, HI80); sb.push_back(e);
      send_word(64'h6162630000000000, 1'b1, 4'd3);

      cnt = 0;
      while ((sb.size() != 0 || bus.blk_valid === 1'b1) && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      repeat (4) @(negedge clk);
      chk("blocks_outstanding", 64'(sb.size()), 64'd0);
      chk("final_blk_valid", 64'(bus.blk_valid), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
